herald_byte_frontend: RTL and testbench
=======================================

Name: herald_byte_frontend

Overview:
- Byte-serial command front end between the 8-bit pad interface and the compute cores (CORDIC, MAC).
- Assembles an opcode plus two 32-bit operands from strobed input bytes, then issues one EN-style command when the core reports RDY.
- Collects the 32-bit result and streams it back as 4 bytes, LSB first, under a strobe/ack handshake.
- Replaces the hard-wired operand zero-extension at the top level.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in WAIT_RES before aborting with err.
- TCW, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ena  in  1  block enable; low aborts to IDLE
- byte_in  in  8  input data byte
- byte_strobe  in  1  synchronous level; a byte is accepted on its rising edge (high now, low last cycle)
- op_a  out  32  assembled operand A
- op_b  out  32  assembled operand B
- op_sel  out  2  opcode: 00 CORDIC, 01 multiply, 10 MAC, 11 clear accumulator
- issue  out  1  single-cycle EN pulse to the selected core
- core_rdy  in  1  RDY of the selected core's start/multiply/mac/clear method
- res_in  in  32  core result
- res_valid  in  1  RDY_get* of the selected core
- res_take  out  1  single-cycle EN_get* pulse
- byte_out  out  8  result byte
- out_valid  out  1  byte_out holds a valid result byte
- out_ack  in  1  level; rising edge advances to the next byte
- busy  out  1  high in every state except IDLE
- err  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0; state IDLE; byte index 0; result register 0; previous strobe and ack samples 0.
- States: IDLE, LOAD_A, LOAD_B, ISSUE, WAIT_RES, SEND.
- IDLE:
  - Strobe edge: header byte. op_sel <= byte_in[1:0]; err cleared; byte index <= 0.
  - byte_in[7:2] are reserved and ignored.
  - op_sel = 11 goes to ISSUE; all other opcodes go to LOAD_A.
- LOAD_A:
  - Each strobe edge writes byte_in into op_a[8*idx+7 : 8*idx], LSB first, then idx++.
  - After the 4th byte: idx <= 0, go to LOAD_B.
  - op_a is not cleared between commands; all 4 bytes are overwritten.
- LOAD_B: same as LOAD_A into op_b; after the 4th byte go to ISSUE.
  - CORDIC treats op_b as don't-care, but the 4 bytes are still required (uniform framing).
- ISSUE:
  - While core_rdy = 0, wait with issue low.
  - In the first cycle core_rdy = 1: issue = 1 for exactly one cycle. op_a, op_b, op_sel are stable during that cycle and the cycle before.
  - Next state: IDLE if op_sel = 11, else WAIT_RES with the timeout counter cleared.
- WAIT_RES:
  - Counter increments each cycle.
  - res_valid = 1: res_take = 1 that same cycle (combinationally qualified by state); res_in is latched into the result register; go to SEND with idx 0.
  - Counter reaches TIMEOUT_CYCLES first: err <= 1, go to IDLE, no res_take.
  - If res_valid and the timeout coincide, res_valid wins.
- SEND:
  - out_valid = 1; byte_out = result[8*idx+7 : 8*idx].
  - Each out_ack rising edge: idx++. After the 4th ack: out_valid = 0, byte_out = 0, go to IDLE.
- Strobe edge in ISSUE, WAIT_RES or SEND: byte ignored, err <= 1, the state machine continues.
- ena = 0 in any state: next cycle go to IDLE, idx 0, issue/res_take/out_valid 0. Operand and result registers are retained; err is unchanged.
- Latency: the last B byte strobe edge is followed by the ISSUE state on the next clock. issue asserts that cycle if core_rdy = 1.
- Asynchronous reset mid-command discards everything and restores reset values.
- busy = (state != IDLE).

Decomposition:
- Shared package herald_pkg:
  - opcode constants OP_CORDIC = 2'b00, OP_MUL = 2'b01, OP_MAC = 2'b10, OP_CLR = 2'b11.
  - the state encoding, a 3-bit enum.
  - BYTES_PER_WORD = 4.
- One natural sub-module: herald_edge_detect, a one-flop rising-edge detector. It is instantiated twice, once for byte_strobe and once for out_ack.

Test Plan:
- Multiply 3×5: strobe header 0x01, A bytes 03 00 00 00, B bytes 05 00 00 00, core_rdy = 1, result 0x0000000F with res_valid 2 cycles after issue.
  - Required: op_sel = 01, op_a = 3, op_b = 5.
  - One issue pulse, then one res_take pulse.
  - Output bytes 0F, 00, 00, 00 on successive acks; busy falls after the 4th ack.
- Byte order: result 0xA1B2C3D4 → byte_out sequence D4, C3, B2, A1.
- Clear: header 0x03 with core_rdy held 0 for 5 cycles, then 1.
  - Required: issue pulses exactly once, in the first core_rdy cycle; returns to IDLE with no res_take and no out_valid.
- Timeout: TIMEOUT_CYCLES = 10, res_valid never asserted → err = 1 and IDLE after 10 cycles in WAIT_RES. The next header clears err.
- Abort: ena dropped after 2 A bytes → IDLE next cycle. A fresh command then loads A from byte 0 correctly.
- Stray strobe during SEND: err = 1, and the remaining result bytes still stream out unchanged.

Source files
------------

// File: rtl/herald_pkg.sv
// Shared definitions for the herald byte-serial command front end.
//   - opcode encodings carried in the header byte (bits [1:0])
//   - FSM state encoding
//   - word framing constants and a byte-lane extraction helper
package herald_pkg;

    localparam logic [1:0] OP_CORDIC = 2'b00;
    localparam logic [1:0] OP_MUL    = 2'b01;
    localparam logic [1:0] OP_MAC    = 2'b10;
    localparam logic [1:0] OP_CLR    = 2'b11;

    localparam int BYTES_PER_WORD = 4;

    // Index of the final byte lane of a word; the byte index wraps after it.
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_A   = 3'd1,
        ST_LOAD_B   = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_SEND     = 3'd5
    } state_t;

    // Byte lane idx of a 32-bit word, lane 0 being the least significant.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[8*idx +: 8];
    endfunction

endpackage

// File: rtl/herald_edge_detect.sv
// One-flop rising-edge detector for a synchronous level input.
//   clk, rst_n : clock, asynchronous active-low reset
//   sig        : level input, already synchronous to clk
//   rise       : high for the cycle in which sig is high and was low last cycle
module herald_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic prev;

    // NOTE: clocked state is written with <= so every flop samples the
    // pre-edge value of its inputs regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= sig;
    end

    assign rise = sig & ~prev;

endmodule

// File: rtl/herald_byte_frontend.sv
// Byte-serial command front end between the 8-bit pad interface and the
// compute cores. A header byte selects the opcode, eight further bytes build
// operands A and B (LSB first), one issue pulse starts the core, and the
// 32-bit result is streamed back as four bytes, LSB first.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   ena          : block enable; low returns to IDLE on the next edge
//   byte_in      : input byte, accepted on a rising edge of byte_strobe
//   byte_strobe  : input byte strobe (level)
//   op_a, op_b   : assembled operands
//   op_sel       : opcode (00 CORDIC, 01 multiply, 10 MAC, 11 clear)
//   issue        : one-cycle start pulse to the selected core
//   core_rdy     : selected core can accept a command
//   res_in       : core result
//   res_valid    : core result available
//   res_take     : one-cycle result-consume pulse
//   byte_out     : current result byte (0 outside SEND)
//   out_valid    : byte_out holds a result byte
//   out_ack      : consumer ack (level); each rising edge advances a byte
//   busy         : state is not IDLE
//   err          : sticky error (timeout or stray strobe), cleared by a header
module herald_byte_frontend
    import herald_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TCW            = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  byte_in,
    input  logic        byte_strobe,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [1:0]  op_sel,
    output logic        issue,
    input  logic        core_rdy,
    input  logic [31:0] res_in,
    input  logic        res_valid,
    output logic        res_take,
    output logic [7:0]  byte_out,
    output logic        out_valid,
    input  logic        out_ack,
    output logic        busy,
    output logic        err
);

    // Counter value in the final permitted WAIT_RES cycle.
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [1:0]      idx;
    logic [31:0]     result;
    logic [TCW-1:0]  tmo_cnt;
    logic            strobe_rise;
    logic            ack_rise;
    logic            stray_state;

    herald_edge_detect u_strobe_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (byte_strobe),
        .rise  (strobe_rise)
    );

    herald_edge_detect u_ack_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (out_ack),
        .rise  (ack_rise)
    );

    // States in which an incoming byte has nowhere to go.
    assign stray_state = (state == ST_ISSUE) || (state == ST_WAIT_RES) || (state == ST_SEND);

    // NOTE: the operand and result words sit in the async reset along with the
    // control state, so a mid-command reset leaves no stale data behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= 2'd0;
            op_a    <= '0;
            op_b    <= '0;
            op_sel  <= OP_CORDIC;
            result  <= '0;
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else if (!ena) begin
            // Abort: operands, result and err are deliberately retained.
            state <= ST_IDLE;
            idx   <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (strobe_rise) begin
                        op_sel <= byte_in[1:0];
                        err    <= 1'b0;
                        idx    <= 2'd0;
                        state  <= (byte_in[1:0] == OP_CLR) ? ST_ISSUE : ST_LOAD_A;
                    end
                end

                ST_LOAD_A: begin
                    if (strobe_rise) begin
                        op_a[8*idx +: 8] <= byte_in;
                        if (idx == LAST_IDX) begin
                            idx   <= 2'd0;
                            state <= ST_LOAD_B;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end

                ST_LOAD_B: begin
                    if (strobe_rise) begin
                        op_b[8*idx +: 8] <= byte_in;
                        if (idx == LAST_IDX) begin
                            idx   <= 2'd0;
                            state <= ST_ISSUE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (core_rdy) begin
                        tmo_cnt <= '0;
                        state   <= (op_sel == OP_CLR) ? ST_IDLE : ST_WAIT_RES;
                    end
                end

                ST_WAIT_RES: begin
                    // A result arriving in the last permitted cycle beats the timeout.
                    if (res_valid) begin
                        result <= res_in;
                        idx    <= 2'd0;
                        state  <= ST_SEND;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_SEND: begin
                    if (ack_rise) begin
                        if (idx == LAST_IDX) begin
                            idx   <= 2'd0;
                            state <= ST_IDLE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase

            if (strobe_rise && stray_state) err <= 1'b1;
        end
    end

    // Handshake pulses are decoded from the registered state so they follow
    // the core's RDY signals within the same cycle.
    assign issue     = ena && (state == ST_ISSUE)    && core_rdy;
    assign res_take  = ena && (state == ST_WAIT_RES) && res_valid;
    assign out_valid = (state == ST_SEND);
    assign busy      = (state != ST_IDLE);

    // NOTE: byte_out gets a default before the conditional so no path through
    // this block leaves it unassigned, which would infer a latch.
    always_comb begin
        byte_out = 8'h00;
        if (state == ST_SEND) byte_out = word_byte(result, idx);
    end

endmodule

// File: tb/tb_herald_byte_frontend.sv
// Directed, table-driven bench for herald_byte_frontend (TIMEOUT_CYCLES = 10).
module tb_herald_byte_frontend;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [7:0]  byte_in;
    logic        byte_strobe;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  op_sel;
    logic        issue;
    logic        core_rdy;
    logic [31:0] res_in;
    logic        res_valid;
    logic        res_take;
    logic [7:0]  byte_out;
    logic        out_valid;
    logic        out_ack;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    herald_byte_frontend #(
        .TIMEOUT_CYCLES (10),
        .TCW            (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .byte_in     (byte_in),
        .byte_strobe (byte_strobe),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_sel      (op_sel),
        .issue       (issue),
        .core_rdy    (core_rdy),
        .res_in      (res_in),
        .res_valid   (res_valid),
        .res_take    (res_take),
        .byte_out    (byte_out),
        .out_valid   (out_valid),
        .out_ack     (out_ack),
        .busy        (busy),
        .err         (err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int issue_cnt = 0;
    int take_cnt  = 0;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (issue)    issue_cnt++;
        if (res_take) take_cnt++;
    end

    typedef struct {
        logic [7:0]       hdr;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [31:0]      res;
        logic [1:0]       exp_sel;
        logic [3:0][7:0]  exp_bytes;   // [0] is the first byte out
        int               lat;         // cycles from issue to res_valid
        bit               stray;       // inject a stray strobe after byte 0
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in     = b;
        byte_strobe = 1'b1;
        tick();
        byte_strobe = 1'b0;
        tick();
    endtask

    // Header, A, B; the last B byte is applied by hand to check issue latency.
    // Returns in the first WAIT_RES cycle (core_rdy must be 1).
    task automatic load_and_issue(input vec_t v, input string tag);
        send_byte(v.hdr);
        for (int i = 0; i < 4; i++) send_byte(v.a[8*i +: 8]);
        for (int i = 0; i < 3; i++) send_byte(v.b[8*i +: 8]);
        byte_in     = v.b[31:24];
        byte_strobe = 1'b1;
        tick();
        check({tag, " issue_latency"}, issue, 1'b1);
        byte_strobe = 1'b0;
        tick();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int ib;
        int tb0;
        ib  = issue_cnt;
        tb0 = take_cnt;
        core_rdy = 1'b1;
        load_and_issue(v, tag);
        repeat (v.lat - 1) tick();
        res_in    = v.res;
        res_valid = 1'b1;
        #1;
        check({tag, " res_take"}, res_take, 1'b1);
        tick();
        res_valid = 1'b0;
        res_in    = '0;
        check({tag, " op_sel"}, op_sel, v.exp_sel);
        check({tag, " op_a"}, op_a, v.a);
        check({tag, " op_b"}, op_b, v.b);
        check({tag, " issue_pulses"}, issue_cnt - ib, 1);
        check({tag, " take_pulses"}, take_cnt - tb0, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s out_valid%0d", tag, i), out_valid, 1'b1);
            check($sformatf("%s byte%0d", tag, i), byte_out, v.exp_bytes[i]);
            out_ack = 1'b1;
            tick();
            out_ack = 1'b0;
            tick();
            if (i == 0 && v.stray) begin
                send_byte(8'h55);
                check({tag, " stray_err"}, err, 1'b1);
            end
        end
        check({tag, " busy_end"}, busy, 1'b0);
        check({tag, " out_valid_end"}, out_valid, 1'b0);
        check({tag, " byte_out_end"}, byte_out, 8'h00);
        check({tag, " err_end"}, err, v.stray);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        int ib;
        int tb0;

        vecs[0] = '{hdr: 8'h01, a: 32'd3, b: 32'd5, res: 32'h0000_000F, exp_sel: 2'b01,
                    exp_bytes: {8'h00, 8'h00, 8'h00, 8'h0F}, lat: 2, stray: 1'b0};
        vecs[1] = '{hdr: 8'h00, a: 32'h1234_5678, b: 32'hDEAD_BEEF, res: 32'hA1B2_C3D4, exp_sel: 2'b00,
                    exp_bytes: {8'hA1, 8'hB2, 8'hC3, 8'hD4}, lat: 1, stray: 1'b0};
        vecs[2] = '{hdr: 8'hFE, a: 32'h0000_FFFF, b: 32'h8000_0001, res: 32'h7F00_FF01, exp_sel: 2'b10,
                    exp_bytes: {8'h7F, 8'h00, 8'hFF, 8'h01}, lat: 5, stray: 1'b1};
        vecs[3] = '{hdr: 8'h01, a: 32'h4433_2211, b: 32'h0000_0002, res: 32'h8866_4422, exp_sel: 2'b01,
                    exp_bytes: {8'h88, 8'h66, 8'h44, 8'h22}, lat: 3, stray: 1'b0};

        rst_n = 1'b0; ena = 1'b1; byte_in = '0; byte_strobe = 1'b0;
        core_rdy = 1'b0; res_in = '0; res_valid = 1'b0; out_ack = 1'b0;
        #12;
        check("rst op_a", op_a, 32'h0);
        check("rst op_b", op_b, 32'h0);
        check("rst op_sel", op_sel, 2'b00);
        check("rst pulses", {issue, res_take, out_valid}, 3'b000);
        check("rst byte_out", byte_out, 8'h00);
        check("rst busy_err", {busy, err}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of loading A.
        send_byte(8'h01);
        send_byte(8'h77);
        check("midrst busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst busy", busy, 1'b0);
        check("midrst op_a", op_a, 32'h0);
        check("midrst op_sel", op_sel, 2'b00);
        tick();
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 3; k++) run_vec(vecs[k], $sformatf("v%0d", k));

        // Clear: core_rdy held low for 5 cycles in ISSUE.
        ib  = issue_cnt;
        tb0 = take_cnt;
        core_rdy = 1'b0;
        send_byte(8'h03);
        check("clr op_sel", op_sel, 2'b11);
        check("clr busy", busy, 1'b1);
        check("clr err_cleared", err, 1'b0);
        repeat (5) begin
            check("clr hold_issue", issue, 1'b0);
            tick();
        end
        core_rdy = 1'b1;
        #1;
        check("clr issue", issue, 1'b1);
        tick();
        check("clr idle", busy, 1'b0);
        tick();
        check("clr issue_pulses", issue_cnt - ib, 1);
        check("clr take_pulses", take_cnt - tb0, 0);
        check("clr out_valid", out_valid, 1'b0);

        // Timeout: 10 cycles in WAIT_RES with no res_valid.
        tb0 = take_cnt;
        load_and_issue(vecs[0], "tmo");
        repeat (9) tick();
        check("tmo busy_last", busy, 1'b1);
        check("tmo err_early", err, 1'b0);
        tick();
        check("tmo idle", busy, 1'b0);
        check("tmo err", err, 1'b1);
        check("tmo take_pulses", take_cnt - tb0, 0);
        check("tmo out_valid", out_valid, 1'b0);

        // Next header clears err; abort after two A bytes.
        send_byte(8'h01);
        check("hdr err_cleared", err, 1'b0);
        send_byte(8'hEE);
        send_byte(8'hEE);
        ena = 1'b0;
        tick();
        check("abort idle", busy, 1'b0);
        check("abort issue", issue, 1'b0);
        ena = 1'b1;
        tick();
        run_vec(vecs[3], "post_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
